reduce_gate_pipe: RTL and testbench
===================================

// Module: reduce_gate_pipe
// PURPOSE
//   Parametrised, pipelined N-input logic-reduction gate. It generalises the fixed four-input
//   AND with pair outputs to WIDTH inputs and a per-sample operator (AND/OR/XOR/NAND).
//   A 2-input tree has one register stage per level, with valid/ready flow control.
//   Sits between input capture logic and downstream condition/flag consumers.
// PARAMETERS
//   WIDTH   4   number of reduced inputs; power of 2, 2..64
//   CNT_W   8   width of the saturating hit counter
//   LEVELS  $clog2(WIDTH) (localparam)  tree depth = pipeline latency in cycles
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   in_valid   in   1        in_data/in_op valid this cycle
//   in_ready   out  1        pipeline can accept a sample this cycle
//   in_data    in   WIDTH    operand bits; bit i is input i
//   in_op      in   2        00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid  out  1        out_result/out_pair valid
//   out_ready  in   1        downstream accepts the output this cycle
//   out_result out  1        full reduction of the sample under its captured op
//   out_pair   out  WIDTH/2  level-1 partials: bit k = in_data[2k] op' in_data[2k+1]
//   hit_count  out  CNT_W    saturating count of accepted outputs with out_result=1
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): all stage valids=0, all data/op regs=0, out_valid=0,
//     out_result=0, out_pair=0, hit_count=0. Reset mid-operation drops in-flight samples.
//   - Global stall: adv = !out_valid || out_ready; in_ready = adv (combinational).
//     If adv=0, no stage register changes. Input handshake = in_valid && in_ready.
//   - Stage 1 captures the level-1 reduction of in_data plus in_op. Stage s (2..LEVELS)
//     reduces stage s-1 pairwise. The op travels with its sample, so op changes between
//     samples never corrupt in-flight data.
//   - op' = base operator: AND for 00 and 11, OR for 01, XOR for 10. NAND inverts only
//     the final out_result. out_pair never inverts.
//   - Stage valid_s <= valid_{s-1} on adv (valid_0 = in_valid). Bubbles are not squeezed.
//   - Latency: accepted at edge t -> out_valid=1 after edge t+LEVELS-1 when no stall.
//     Throughput: 1 sample/cycle.
//   - out_pair delay: level-1 partials are delayed through LEVELS-1 extra regs (enabled
//     by adv) so out_pair stays aligned with out_result. WIDTH=2: out_pair[0] is the
//     pre-inversion final value.
//   - Outputs hold stable while out_valid=1 && out_ready=0.
//   - hit_count += 1 on each out_valid && out_ready && out_result. Saturates at
//     2^CNT_W-1 and never wraps. Cleared only by reset.
//   - Reset has priority over the stall state and all handshakes in the same cycle.
// TESTING (WIDTH=4, LEVELS=2, CNT_W=8 unless noted)
//   1 Exhaustive AND sweep: all 16 in_data values, op=00, out_ready=1. Each result appears
//     2 cycles after its input. Result is 1 only for 4'hF. out_pair={d3&d2,d1&d0}.
//   2 Per-sample op: back-to-back 4'b0110 with op 00, 01, 10, 11 -> results 0, 1, 0, 1.
//     out_pair for these samples is 2'b00, 2'b11, 2'b11, 2'b00.
//   3 Backpressure: hold out_ready=0 for 5 cycles with 3 samples in flight.
//     in_ready=0, outputs stay frozen, and no sample is lost or duplicated after release.
//   4 Reset mid-flight: drop rst_n for 1 cycle with 2 valid samples in the pipe.
//     out_valid=0 next cycle, hit_count=0, no stale output appears afterward.
//   5 Saturation: CNT_W=2, 5 accepted results of 1 -> hit_count sequence 1,2,3,3,3.
//   6 WIDTH=64: random 1000 samples and ops, out_ready toggling randomly. Outputs match a
//     reference reduction queue in order, with latency 6 when not stalled.

Source files
------------

// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe
//   Pipelined N-input logic reduction gate. A binary tree of 2-input gates
//   reduces WIDTH operand bits to one result, with one register stage per
//   tree level. The operator is chosen per sample: AND, OR, XOR or NAND.
//   Valid/ready flow control uses a single global stall. A saturating counter
//   records how many accepted outputs had a result of 1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data/in_op hold a sample this cycle
//   in_ready   pipeline accepts a sample this cycle
//   in_data    WIDTH operand bits, bit i is input i
//   in_op      00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid  out_result/out_pair hold a sample
//   out_ready  downstream accepts the output this cycle
//   out_result full reduction under the sample's operator
//   out_pair   level-1 partials (never inverted), aligned with out_result
//   hit_count  saturating count of accepted outputs with out_result=1

module reduce_gate_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_result,
    output logic [WIDTH/2-1:0] out_pair,
    output logic [CNT_W-1:0]   hit_count
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int HALF   = WIDTH / 2;

    // NAND reduces with AND and inverts only the final result.
    function automatic logic base_op(input logic a, input logic b, input logic [1:0] op);
        case (op)
            2'b01:   base_op = a | b;
            2'b10:   base_op = a ^ b;
            default: base_op = a & b;
        endcase
    endfunction

    // All tree levels are packed into one vector: level s starts at
    // WIDTH - (WIDTH >> (s-1)) and is WIDTH >> s bits wide, so the whole
    // tree needs WIDTH-1 bits and the final bit sits at WIDTH-2.
    function automatic int lvl_off(input int s);
        lvl_off = WIDTH - (WIDTH >> (s - 1));
    endfunction

    logic [WIDTH-2:0]  tree_d;
    logic [WIDTH-2:0]  tree_p;
    logic [LEVELS:1]   vld_p;
    logic [1:0]        op_p   [1:LEVELS];
    logic [HALF-1:0]   pair_p [1:LEVELS];
    logic              adv;

    // One global enable: the whole pipe moves unless a valid output is
    // waiting on downstream. Bubbles move along with data.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0 -> 1 and stage s-1 -> s combinational reductions; each level
    // uses the op that travelled with its own sample.
    always_comb begin
        tree_d = '0;
        for (int k = 0; k < HALF; k++) begin
            tree_d[k] = base_op(in_data[2*k], in_data[2*k+1], in_op);
        end
        for (int s = 2; s <= LEVELS; s++) begin
            for (int k = 0; k < (WIDTH >> s); k++) begin
                tree_d[lvl_off(s) + k] = base_op(tree_p[lvl_off(s-1) + 2*k],
                                                 tree_p[lvl_off(s-1) + 2*k + 1],
                                                 op_p[s-1]);
            end
        end
    end

    // Stage registers: tree levels, op, valid and the delayed level-1
    // partials that keep out_pair aligned with out_result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tree_p    <= '0;
            vld_p     <= '0;
            hit_count <= '0;
            for (int s = 1; s <= LEVELS; s++) begin
                op_p[s]   <= '0;
                pair_p[s] <= '0;
            end
        end else begin
            if (adv) begin
                tree_p    <= tree_d;
                vld_p[1]  <= in_valid;
                op_p[1]   <= in_op;
                pair_p[1] <= tree_d[HALF-1:0];
                for (int s = 2; s <= LEVELS; s++) begin
                    vld_p[s]  <= vld_p[s-1];
                    op_p[s]   <= op_p[s-1];
                    pair_p[s] <= pair_p[s-1];
                end
            end
            if (out_valid && out_ready && out_result && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

    // Output stage
    assign out_valid  = vld_p[LEVELS];
    assign out_result = tree_p[WIDTH-2] ^ (op_p[LEVELS] == 2'b11);
    assign out_pair   = pair_p[LEVELS];

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb_reduce_gate_pipe
//   Directed bench for reduce_gate_pipe: a WIDTH=4 instance for the main
//   function, backpressure and reset cases, a CNT_W=2 instance for counter
//   saturation, and a WIDTH=64 instance checked against a reference queue.

module tb_reduce_gate_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=4, CNT_W=8
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_result;
    logic [3:0] a_in_data;
    logic [1:0] a_in_op, a_out_pair;
    logic [7:0] a_hit;

    // WIDTH=4, CNT_W=2
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_result;
    logic [3:0] s_in_data;
    logic [1:0] s_in_op, s_out_pair, s_hit;

    // WIDTH=64, CNT_W=8
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_result;
    logic [63:0] w_in_data;
    logic [1:0]  w_in_op;
    logic [31:0] w_out_pair;
    logic [7:0]  w_hit;

    reduce_gate_pipe #(.WIDTH(4), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
        .out_pair(a_out_pair), .hit_count(a_hit)
    );

    reduce_gate_pipe #(.WIDTH(4), .CNT_W(2)) u_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_op(s_in_op),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
        .out_pair(s_out_pair), .hit_count(s_hit)
    );

    reduce_gate_pipe #(.WIDTH(64), .CNT_W(8)) u_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_op(w_in_op),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_result(w_out_result),
        .out_pair(w_out_pair), .hit_count(w_hit)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: whole-word reduction plus per-pair partials.
    function automatic logic [32:0] wide_ref(input logic [63:0] d, input logic [1:0] op);
        logic [31:0] p;
        logic        r;
        for (int k = 0; k < 32; k++) begin
            case (op)
                2'b01:   p[k] = d[2*k] | d[2*k+1];
                2'b10:   p[k] = d[2*k] ^ d[2*k+1];
                default: p[k] = d[2*k] & d[2*k+1];
            endcase
        end
        case (op)
            2'b01:   r = |d;
            2'b10:   r = ^d;
            default: r = &d;
        endcase
        if (op == 2'b11) r = ~r;
        return {r, p};
    endfunction

    function automatic logic [63:0] wide_data();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return ~(64'd1 << $urandom_range(0, 63));
            3:       return 64'd1 << $urandom_range(0, 63);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [3:0]  d;
    logic [1:0]  t2_op   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic        t2_res  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  t2_pair [4] = '{2'b00, 2'b11, 2'b11, 2'b00};
    logic [1:0]  t5_hit  [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [32:0] q [$];
    logic [32:0] e;
    int          pushed, cyc, lat;

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_op = '0; a_out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_in_op = '0; s_out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_data = '0; w_in_op = '0; w_out_ready = 1'b1;
        tick();
        tick();

        // reset state
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_result", a_out_result, 0);
        chk("rst_out_pair", a_out_pair, 0);
        chk("rst_hit", a_hit, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_w_out_valid", w_out_valid, 0);
        rst_n = 1'b1;
        tick();

        // exhaustive AND sweep, one sample per cycle, two-cycle latency
        for (int i = 0; i <= 16; i++) begin
            a_in_valid = (i < 16);
            a_in_data  = 4'(i);
            a_in_op    = 2'b00;
            tick();
            if (i >= 1) begin
                d = 4'(i - 1);
                chk("and_valid", a_out_valid, 1);
                chk("and_result", a_out_result, (d == 4'hF));
                chk("and_pair", a_out_pair, {d[3] & d[2], d[1] & d[0]});
            end
        end
        a_in_valid = 1'b0;
        tick();
        chk("and_drained", a_out_valid, 0);
        chk("and_hit", a_hit, 1);

        // per-sample operator on 4'b0110
        for (int i = 0; i <= 4; i++) begin
            a_in_valid = (i < 4);
            a_in_data  = 4'b0110;
            a_in_op    = (i < 4) ? t2_op[i] : 2'b00;
            tick();
            if (i >= 1) begin
                chk("op_valid", a_out_valid, 1);
                chk("op_result", a_out_result, t2_res[i-1]);
                chk("op_pair", a_out_pair, t2_pair[i-1]);
            end
        end
        a_in_valid = 1'b0;
        tick();
        chk("op_drained", a_out_valid, 0);
        chk("op_hit", a_hit, 3);

        // backpressure: A=F/AND, B=1000/XOR, C=0011/OR
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 4'hF; a_in_op = 2'b00;
        tick();
        chk("bp_fill_valid", a_out_valid, 0);
        a_in_data = 4'b1000; a_in_op = 2'b10;
        tick();
        a_in_data = 4'b0011; a_in_op = 2'b01;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", a_in_ready, 0);
            chk("bp_hold_valid", a_out_valid, 1);
            chk("bp_hold_result", a_out_result, 1);
            chk("bp_hold_pair", a_out_pair, 2'b11);
            chk("bp_hold_hit", a_hit, 3);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        chk("bp_b_valid", a_out_valid, 1);
        chk("bp_b_result", a_out_result, 1);
        chk("bp_b_pair", a_out_pair, 2'b10);
        chk("bp_b_hit", a_hit, 4);
        tick();
        chk("bp_c_valid", a_out_valid, 1);
        chk("bp_c_result", a_out_result, 1);
        chk("bp_c_pair", a_out_pair, 2'b01);
        chk("bp_c_hit", a_hit, 5);
        tick();
        chk("bp_end_valid", a_out_valid, 0);
        chk("bp_end_hit", a_hit, 6);

        // reset with two samples in flight
        a_in_valid = 1'b1; a_in_data = 4'hF; a_in_op = 2'b00;
        tick();
        a_in_op = 2'b01;
        tick();
        chk("rmid_pre_valid", a_out_valid, 1);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rmid_valid", a_out_valid, 0);
        chk("rmid_hit", a_hit, 0);
        chk("rmid_result", a_out_result, 0);
        chk("rmid_pair", a_out_pair, 0);
        rst_n = 1'b1;
        tick();
        chk("rmid_stale1", a_out_valid, 0);
        tick();
        chk("rmid_stale2", a_out_valid, 0);
        chk("rmid_hit_after", a_hit, 0);

        // counter saturation on the CNT_W=2 instance
        for (int i = 0; i <= 6; i++) begin
            s_in_valid = (i < 5);
            s_in_data  = 4'hF;
            s_in_op    = 2'b00;
            tick();
            chk("sat_hit", s_hit, t5_hit[i]);
        end
        s_in_valid = 1'b0;

        // WIDTH=64 random stream with random backpressure
        pushed = 0;
        cyc    = 0;
        while (pushed < 1000 && cyc < 6000) begin
            w_out_ready = ($urandom_range(0, 3) != 0);
            w_in_valid  = ($urandom_range(0, 4) != 0);
            w_in_data   = wide_data();
            w_in_op     = 2'($urandom_range(0, 3));
            #1;
            if (w_out_valid && w_out_ready) begin
                if (q.size() == 0) begin
                    chk("wide_extra_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("wide_out", {w_out_result, w_out_pair}, e);
                end
            end
            if (w_in_valid && w_in_ready) begin
                q.push_back(wide_ref(w_in_data, w_in_op));
                pushed++;
            end
            tick();
            cyc++;
        end
        chk("wide_pushed", pushed, 1000);
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            #1;
            if (w_out_valid) begin
                e = q.pop_front();
                chk("wide_drain_out", {w_out_result, w_out_pair}, e);
            end
            tick();
            cyc++;
        end
        chk("wide_queue_empty", q.size(), 0);
        chk("wide_idle", w_out_valid, 0);

        // unstalled latency of the WIDTH=64 pipe
        w_in_valid = 1'b1; w_in_data = '1; w_in_op = 2'b00;
        tick();
        w_in_valid = 1'b0;
        lat = 1;
        while (!w_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("wide_latency", lat, 6);
        chk("wide_lat_out", {w_out_result, w_out_pair}, 33'h1_FFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
